// File: rtl/bcd_down_cntr_sync.sv
// bcd_down_cntr_sync: multi-digit packed BCD down-counter with sanitising parallel load,
// zero flag, terminal-count pulse and load-error pulse.
module bcd_down_cntr_sync #(
  parameter int NDIG = 2,
  parameter bit WRAP = 1'b0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic [4*NDIG-1:0] load_val,
  input  logic              cnt_en,
  output logic [4*NDIG-1:0] count,
  output logic              zero,
  output logic              tc_pulse,
  output logic              load_err
);
  localparam int W = 4 * NDIG;
  logic [W-1:0]    r_count;
  logic            r_zero;
  logic            r_tc;
  logic            r_lerr;
  logic [W-1:0]    w_dec;
  logic [W-1:0]    w_sat;
  logic [NDIG-1:0] w_bad;
  logic [W-1:0]    w_next;
  logic            w_tc;
  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    logic [3:0] w_d;
    logic       w_bin;
    assign w_d = r_count[4*g +: 4];
    // A digit sees the borrow exactly when every lower digit is zero.
    if (g == 0) begin : g_lsd
      assign w_bin = 1'b1;
    end else begin : g_upper
      assign w_bin = ~|r_count[4*g-1:0];
    end
    assign w_dec[4*g +: 4] = !w_bin ? w_d : (w_d == 4'd0 ? 4'd9 : w_d - 4'd1);
    assign w_bad[g]        = load_val[4*g +: 4] > 4'd9;
    assign w_sat[4*g +: 4] = w_bad[g] ? 4'd9 : load_val[4*g +: 4];
  end
  assign w_next = load ? w_sat : !cnt_en ? r_count : (r_zero && !WRAP) ? r_count : w_dec;
  assign w_tc   = !load && cnt_en && !r_zero && (w_dec == '0);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
      r_zero  <= 1'b1;
      r_tc    <= 1'b0;
      r_lerr  <= 1'b0;
    end else begin
      r_count <= w_next;
      r_zero  <= (w_next == '0);
      r_tc    <= w_tc;
      r_lerr  <= load && |w_bad;
    end
  end
  assign count    = r_count;
  assign zero     = r_zero;
  assign tc_pulse = r_tc;
  assign load_err = r_lerr;
endmodule

// File: tb/tb_bcd_down_cntr_sync.sv
// tb_bcd_down_cntr_sync: drives a hold-at-zero and a wrapping counter in lockstep and
// checks both against a decimal integer model.
module tb_bcd_down_cntr_sync;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = '0;
  logic       cnt_en = 1'b0;
  logic [7:0] c0, c1;
  logic       z0, z1, t0, t1, e0, e1;
  int         n_chk = 0;
  int         n_err = 0;
  int         m[2];
  logic       exp_tc[2];
  logic       exp_le;

  bcd_down_cntr_sync #(.NDIG(2), .WRAP(1'b0)) u_hold (
    .clk(clk), .rstn(rstn), .load(load), .load_val(load_val), .cnt_en(cnt_en),
    .count(c0), .zero(z0), .tc_pulse(t0), .load_err(e0));
  bcd_down_cntr_sync #(.NDIG(2), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rstn(rstn), .load(load), .load_val(load_val), .cnt_en(cnt_en),
    .count(c1), .zero(z1), .tc_pulse(t1), .load_err(e1));

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int clampv(input logic [7:0] b);
    int hi, lo;
    hi = b[7:4] > 4'd9 ? 9 : int'(b[7:4]);
    lo = b[3:0] > 4'd9 ? 9 : int'(b[3:0]);
    return hi * 10 + lo;
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, " count0"}, c0, to_bcd(m[0]));
    chk({tag, " zero0"}, 8'(z0), 8'(m[0] == 0));
    chk({tag, " tc0"}, 8'(t0), 8'(exp_tc[0]));
    chk({tag, " lerr0"}, 8'(e0), 8'(exp_le));
    chk({tag, " count1"}, c1, to_bcd(m[1]));
    chk({tag, " zero1"}, 8'(z1), 8'(m[1] == 0));
    chk({tag, " tc1"}, 8'(t1), 8'(exp_tc[1]));
    chk({tag, " lerr1"}, 8'(e1), 8'(exp_le));
  endtask

  task automatic model_reset();
    m = '{0, 0};
    exp_tc = '{1'b0, 1'b0};
    exp_le = 1'b0;
  endtask

  task automatic step(input string tag, input logic l, input logic [7:0] v, input logic e);
    load = l;
    load_val = v;
    cnt_en = e;
    @(posedge clk);
    exp_le = l && (v[7:4] > 4'd9 || v[3:0] > 4'd9);
    for (int w = 0; w < 2; w++) begin
      exp_tc[w] = !l && e && m[w] == 1;
      if (l) m[w] = clampv(v);
      else if (e) m[w] = m[w] > 0 ? m[w] - 1 : (w == 1 ? 99 : 0);
    end
    #1 compare_all(tag);
  endtask

  initial begin
    model_reset();
    #7 compare_all("reset");
    rstn = 1'b1;
    @(posedge clk);
    #1;
    step("load25", 1'b1, 8'h25, 1'b0);
    for (int i = 0; i < 25; i++) step("down25", 1'b0, 8'h00, 1'b1);
    step("hold0", 1'b0, 8'h00, 1'b1);
    step("idle", 1'b0, 8'h00, 1'b0);
    step("load10", 1'b1, 8'h10, 1'b0);
    step("borrow", 1'b0, 8'h00, 1'b1);
    step("load00", 1'b1, 8'h00, 1'b0);
    step("loadA3", 1'b1, 8'hA3, 1'b0);
    step("after_err", 1'b0, 8'h00, 1'b0);
    step("loadFF", 1'b1, 8'hFF, 1'b0);
    step("load42", 1'b1, 8'h42, 1'b0);
    step("load58", 1'b1, 8'h58, 1'b0);
    step("to57", 1'b0, 8'h00, 1'b1);
    cnt_en = 1'b1;
    #3 rstn = 1'b0;
    model_reset();
    #1 compare_all("async_rst");
    repeat (2) begin
      @(posedge clk);
      #1 compare_all("rst_hold");
    end
    rstn = 1'b1;
    step("resume", 1'b0, 8'h00, 1'b1);
    step("resume2", 1'b0, 8'h00, 1'b1);
    step("ld_en", 1'b1, 8'h31, 1'b1);
    step("after_ld_en", 1'b0, 8'h00, 1'b1);
    step("load01", 1'b1, 8'h01, 1'b0);
    step("tc_again", 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 400; i++) begin
      logic [7:0] v;
      v = ($urandom % 3 == 0) ? 8'($urandom) : to_bcd(int'($urandom_range(0, 4)));
      step("rand", ($urandom % 6) == 0, v, ($urandom % 4) != 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
